// File: rtl/move_pkg.sv
// Character motion states and default playfield geometry.
package move_pkg;
   import vga_pkg::*;

   typedef enum logic [1:0] {
      ST_STAND = 2'd0,
      ST_WALK  = 2'd1,
      ST_JUMP  = 2'd2,
      ST_FALL  = 2'd3
   } state_e;

   localparam int CHAR_W      = 32;
   localparam int DEF_X_MIN   = 0;
   localparam int DEF_X_MAX   = HOR_PIXELS - CHAR_W;
   localparam int DEF_Y_FLOOR = 533;
   localparam int DEF_X_START = 100;
   localparam int DEF_Y_START = 533;
endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by the video and game-logic blocks.
package vga_pkg;
   localparam int HOR_PIXELS = 1024;
   localparam int VER_PIXELS = 768;
endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every DIV enabled cycles.
module tick_gen #(
   parameter int DIV = 10000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         if (cnt_q == CW'(DIV - 1)) cnt_d = '0;
         else                       cnt_d = cnt_q + CW'(1);
      end
   end

   assign tick = en & (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/char_motion_ctrl.sv
// Platformer character controller: walk, jump and fall with
// wall/ceiling/floor collision, driven by two divided motion ticks.
module char_motion_ctrl
   import move_pkg::*;
#(
   parameter int POS_W       = 12,
   parameter int X_MIN       = DEF_X_MIN,
   parameter int X_MAX       = DEF_X_MAX,
   parameter int Y_FLOOR     = DEF_Y_FLOOR,
   parameter int X_START     = DEF_X_START,
   parameter int Y_START     = DEF_Y_START,
   parameter int HOR_SPEED   = 3,
   parameter int JUMP_HEIGHT = 100,
   parameter int HOR_DIV     = 10000,
   parameter int VER_DIV     = 150000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             respawn,
   input  logic             key_left,
   input  logic             key_right,
   input  logic             key_jump,
   input  logic             ground,
   input  logic             ceiling,
   input  logic             wall_l,
   input  logic             wall_r,
   output logic [POS_W-1:0] pos_x,
   output logic [POS_W-1:0] pos_y,
   output logic [1:0]       state_o,
   output logic             airborne
);
   localparam logic [POS_W:0] XMIN_W = (POS_W+1)'(X_MIN);
   localparam logic [POS_W:0] XMAX_W = (POS_W+1)'(X_MAX);
   localparam logic [POS_W:0] HSP_W  = (POS_W+1)'(HOR_SPEED);
   localparam logic [POS_W-1:0] XMIN = POS_W'(X_MIN);
   localparam logic [POS_W-1:0] XMAX = POS_W'(X_MAX);
   localparam logic [POS_W-1:0] HSP  = POS_W'(HOR_SPEED);
   localparam logic [POS_W-1:0] YFLR = POS_W'(Y_FLOOR);
   localparam logic [POS_W-1:0] JH   = POS_W'(JUMP_HEIGHT);
   localparam logic [POS_W-1:0] XST  = POS_W'(X_START);
   localparam logic [POS_W-1:0] YST  = POS_W'(Y_START);

   logic tick_hor, tick_ver;

   tick_gen #(.DIV(HOR_DIV)) u_tick_hor (
      .clk  (clk),
      .rst  (rst),
      .en   (enable),
      .tick (tick_hor)
   );

   tick_gen #(.DIV(VER_DIV)) u_tick_ver (
      .clk  (clk),
      .rst  (rst),
      .en   (enable),
      .tick (tick_ver)
   );

   state_e           state_q, state_d;
   logic [POS_W-1:0] pos_x_q, pos_x_d;
   logic [POS_W-1:0] pos_y_q, pos_y_d;
   logic [POS_W-1:0] y_start_q, y_start_d;
   logic             jump_prev_q;
   logic             airborne_q, airborne_d;

   logic             grounded, jump_req, one_l, one_r;
   logic [POS_W-1:0] y_lim;
   logic [POS_W:0]   x_ext;

   always_comb begin
      grounded  = ground | (pos_y_q >= YFLR);
      jump_req  = key_jump & ~jump_prev_q;
      one_l     = key_left & ~key_right;
      one_r     = key_right & ~key_left;
      x_ext     = {1'b0, pos_x_q};
      // apex limit clamps at the top of the screen
      y_lim     = (y_start_q >= JH) ? (y_start_q - JH) : '0;

      state_d   = state_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      y_start_d = y_start_q;

      if (respawn) begin
         state_d = ST_STAND;
         pos_x_d = XST;
         pos_y_d = YST;
      end else if (enable) begin
         if (tick_hor) begin
            if (one_l && !wall_l) begin
               if (x_ext < XMIN_W + HSP_W) pos_x_d = XMIN;
               else                        pos_x_d = pos_x_q - HSP;
            end else if (one_r && !wall_r) begin
               if (x_ext + HSP_W > XMAX_W) pos_x_d = XMAX;
               else                        pos_x_d = pos_x_q + HSP;
            end
         end

         unique case (state_q)
            ST_STAND, ST_WALK: begin
               if (jump_req && grounded) begin
                  state_d   = ST_JUMP;
                  y_start_d = pos_y_q;
               end else if (!grounded) begin
                  state_d = ST_FALL;
               end else if (one_l || one_r) begin
                  state_d = ST_WALK;
               end else begin
                  state_d = ST_STAND;
               end
            end
            ST_JUMP: begin
               if (pos_y_q <= y_lim || ceiling || pos_y_q == '0)
                  state_d = ST_FALL;
               else if (tick_ver)
                  pos_y_d = pos_y_q - POS_W'(1);
            end
            ST_FALL: begin
               if (grounded)
                  state_d = ST_STAND;
               else if (tick_ver)
                  pos_y_d = (pos_y_q >= YFLR - POS_W'(1)) ? YFLR
                                                          : pos_y_q + POS_W'(1);
            end
         endcase
      end

      airborne_d = (state_d == ST_JUMP) || (state_d == ST_FALL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_STAND;
         pos_x_q     <= XST;
         pos_y_q     <= YST;
         y_start_q   <= YST;
         jump_prev_q <= 1'b0;
         airborne_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         y_start_q   <= y_start_d;
         jump_prev_q <= key_jump;
         airborne_q  <= airborne_d;
      end
   end

   assign pos_x    = pos_x_q;
   assign pos_y    = pos_y_q;
   assign state_o  = state_q;
   assign airborne = airborne_q;
endmodule

// File: tb/tb_char_motion_ctrl.sv
// Directed table plus multi-cycle jump/fall sequences for char_motion_ctrl.
module tb_char_motion_ctrl;
   localparam int HD = 4;
   localparam int VD = 6;

   logic clk = 1'b0;
   logic rst, enable, respawn;
   logic key_left, key_right, key_jump;
   logic ground, ceiling, wall_l, wall_r;
   logic [11:0] pos_x, pos_y;
   logic [1:0]  state_o;
   logic        airborne;

   int nvec  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   char_motion_ctrl #(.HOR_DIV(HD), .VER_DIV(VD)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .respawn   (respawn),
      .key_left  (key_left),
      .key_right (key_right),
      .key_jump  (key_jump),
      .ground    (ground),
      .ceiling   (ceiling),
      .wall_l    (wall_l),
      .wall_r    (wall_r),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .state_o   (state_o),
      .airborne  (airborne)
   );

   typedef struct {
      logic en, rsp, l, r, g, wl, wr;
      int   n;
      int   ex, ey, es;
   } vec_t;

   vec_t tv[13];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic wait_state(input string nm, input int st, input int lim);
      int n;
      for (n = 0; n < lim && int'(state_o) != st; n++) step(1);
      check({nm, "_timeout"}, int'(n < lim), 1);
   endtask

   task automatic wait_y(input string nm, input int y, input int lim);
      int n;
      for (n = 0; n < lim && int'(pos_y) != y; n++) step(1);
      check({nm, "_timeout"}, int'(n < lim), 1);
   endtask

   // jump from a platform, stop at stop_y (ceiling or apex), land there
   task automatic jump_to(input string nm, input int stop_y, input bit use_ceil);
      key_jump = 1'b0; ground = 1'b1; ceiling = 1'b0;
      step(1);
      key_jump = 1'b1;
      step(1);
      check({nm, "_st_jump"}, int'(state_o), 2);
      ground = 1'b0;
      if (use_ceil) begin
         wait_y(nm, stop_y, 1000);
         check({nm, "_still_jump"}, int'(state_o), 2);
         ceiling = 1'b1; ground = 1'b1;
         step(1);
         check({nm, "_st_fall"}, int'(state_o), 3);
      end else begin
         wait_state(nm, 3, 1000);
         check({nm, "_apex_y"}, int'(pos_y), stop_y);
         ground = 1'b1;
      end
      step(1);
      check({nm, "_land_st"}, int'(state_o), 0);
      check({nm, "_land_y"}, int'(pos_y), stop_y);
      ceiling = 1'b0; key_jump = 1'b0;
   endtask

   initial begin
      //        en rsp l  r  g  wl wr   n     x    y  st
      tv[0]  = '{1, 0, 0, 0, 1, 0, 0,   36, 100, 533, 0};
      tv[1]  = '{1, 0, 0, 1, 1, 0, 0,   40, 130, 533, 1};
      tv[2]  = '{1, 0, 0, 1, 1, 0, 1,   20, 130, 533, 1};
      tv[3]  = '{1, 0, 1, 1, 1, 0, 0,   20, 130, 533, 0};
      tv[4]  = '{1, 0, 1, 0, 1, 0, 0,    8, 124, 533, 1};
      tv[5]  = '{0, 0, 0, 1, 1, 0, 0,   20, 124, 533, 1};
      tv[6]  = '{1, 0, 0, 1, 1, 0, 0,    4, 127, 533, 1};
      tv[7]  = '{1, 1, 0, 0, 1, 0, 0,    1, 100, 533, 0};
      tv[8]  = '{1, 0, 1, 0, 1, 0, 0,  136,   0, 533, 1};
      tv[9]  = '{1, 0, 1, 0, 1, 0, 0,   20,   0, 533, 1};
      tv[10] = '{1, 0, 0, 1, 1, 0, 0, 1400, 992, 533, 1};
      tv[11] = '{1, 1, 0, 0, 1, 0, 0,    1, 100, 533, 0};
      tv[12] = '{1, 0, 0, 0, 1, 0, 0,    4, 100, 533, 0};

      rst = 1'b1; enable = 1'b1; respawn = 1'b0;
      key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
      ground = 1'b1; ceiling = 1'b0; wall_l = 1'b0; wall_r = 1'b0;
      step(3);
      rst = 1'b0;
      check("rst_x", int'(pos_x), 100);
      check("rst_y", int'(pos_y), 533);
      check("rst_st", int'(state_o), 0);
      check("rst_air", int'(airborne), 0);

      for (int i = 0; i < 13; i++) begin
         enable = tv[i].en; respawn = tv[i].rsp;
         key_left = tv[i].l; key_right = tv[i].r; ground = tv[i].g;
         wall_l = tv[i].wl; wall_r = tv[i].wr;
         step(tv[i].n);
         check($sformatf("v%0d_x", i), int'(pos_x), tv[i].ex);
         check($sformatf("v%0d_y", i), int'(pos_y), tv[i].ey);
         check($sformatf("v%0d_st", i), int'(state_o), tv[i].es);
      end
      respawn = 1'b0; enable = 1'b1;
      key_left = 1'b0; key_right = 1'b0; wall_l = 1'b0; wall_r = 1'b0;

      // full jump from the floor and back, key held throughout
      key_jump = 1'b1; ground = 1'b0;
      step(1);
      check("j_st", int'(state_o), 2);
      check("j_air", int'(airborne), 1);
      wait_state("j_apex", 3, 1500);
      check("j_apex_y", int'(pos_y), 433);
      wait_state("j_land", 0, 1500);
      check("j_land_y", int'(pos_y), 533);
      check("j_land_air", int'(airborne), 0);
      step(200);
      check("j_hold_st", int'(state_o), 0);
      check("j_hold_y", int'(pos_y), 533);
      key_jump = 1'b0;
      step(1);

      // ceiling after 20 vertical ticks
      key_jump = 1'b1;
      step(1);
      wait_y("c", 513, 500);
      ceiling = 1'b1;
      step(1);
      check("c_st", int'(state_o), 3);
      check("c_y", int'(pos_y), 513);
      ceiling = 1'b0; key_jump = 1'b0;
      wait_state("c_land", 0, 500);
      check("c_land_y", int'(pos_y), 533);

      // climb to a platform at 400, then walk off it
      jump_to("p1", 433, 1'b0);
      jump_to("p2", 400, 1'b1);
      key_right = 1'b1; ground = 1'b1;
      step(8);
      check("wo_walk", int'(state_o), 1);
      ground = 1'b0;
      step(1);
      check("wo_fall", int'(state_o), 3);
      key_right = 1'b0;
      wait_y("wo", 420, 300);
      ground = 1'b1;
      step(1);
      check("wo_land_st", int'(state_o), 0);
      check("wo_land_y", int'(pos_y), 420);

      // climb near the top; last jump starts below JUMP_HEIGHT
      jump_to("p3", 320, 1'b0);
      jump_to("p4", 220, 1'b0);
      jump_to("p5", 120, 1'b0);
      jump_to("p6", 50, 1'b1);
      jump_to("p7", 0, 1'b0);

      respawn = 1'b1;
      step(1);
      respawn = 1'b0;
      check("rs_x", int'(pos_x), 100);
      check("rs_y", int'(pos_y), 533);

      // respawn while frozen mid-jump
      key_jump = 1'b1; ground = 1'b0;
      step(1);
      step(30);
      check("rf_air", int'(airborne), 1);
      enable = 1'b0; respawn = 1'b1;
      step(1);
      respawn = 1'b0;
      check("rf_x", int'(pos_x), 100);
      check("rf_y", int'(pos_y), 533);
      check("rf_st", int'(state_o), 0);
      check("rf_air0", int'(airborne), 0);
      step(10);
      check("rf_hold_st", int'(state_o), 0);
      enable = 1'b1; key_jump = 1'b0; ground = 1'b1;
      step(1);

      // reset mid-jump
      key_jump = 1'b1; ground = 1'b0;
      step(1);
      step(30);
      rst = 1'b1; key_jump = 1'b0;
      step(1);
      rst = 1'b0;
      check("rm_y", int'(pos_y), 533);
      check("rm_st", int'(state_o), 0);
      check("rm_air", int'(airborne), 0);
      step(24);
      check("rm_y2", int'(pos_y), 533);
      check("rm_st2", int'(state_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/char_motion_ctrl.md
CHAR_MOTION_CTRL -- requirements
Module: char_motion_ctrl

Interface
REQ-001 Parameter POS_W, 12, width of position outputs.
REQ-002 Parameter X_MIN, 0, leftmost allowed pos_x.
REQ-003 Parameter X_MAX, 1024-32, rightmost allowed pos_x.
REQ-004 Parameter Y_FLOOR, 533, lowest allowed pos_y; pos_y >= Y_FLOOR counts as grounded.
REQ-005 Parameter X_START / Y_START, 100 / 533, reset and respawn position.
REQ-006 Parameter HOR_SPEED, 3, pixels per horizontal tick.
REQ-007 Parameter JUMP_HEIGHT, 100, maximum rise in pixels per jump.
REQ-008 Parameter HOR_DIV / VER_DIV, 10000 / 150000, clock cycles per horizontal / vertical tick.
REQ-009 clk  in  1  system clock; all logic on its rising edge.
REQ-010 rst  in  1  reset, synchronous, active-high.
REQ-011 enable  in  1  1 = motion allowed; 0 = freeze position and state.
REQ-012 respawn  in  1  single-cycle pulse; return to start position.
REQ-013 key_left / key_right / key_jump  in  1 each  player controls, level.
REQ-014 ground  in  1  platform directly below character.
REQ-015 ceiling  in  1  obstacle directly above character.
REQ-016 wall_l / wall_r  in  1 each  obstacle adjacent left / right.
REQ-017 pos_x / pos_y  out  POS_W each  top-left character position, registered.
REQ-018 state_o  out  2  current state code.
REQ-019 airborne  out  1  1 in JUMP or FALL.

Function
REQ-020 Two free-running dividers SHALL assert tick_hor and tick_ver for one cycle each, every HOR_DIV and VER_DIV cycles; the first tick occurs in the cycle after reset.
REQ-021 States: STAND=0, WALK=1, JUMP=2, FALL=3; transitions evaluate every cycle while enable=1; positions change only on ticks.
REQ-022 Grounded = ground | (pos_y >= Y_FLOOR).
REQ-023 Jump request SHALL be the rising edge of key_jump (registered previous value); held key SHALL NOT re-trigger.
REQ-024 STAND/WALK: jump request and grounded -> JUMP, latch y_start = pos_y; else not grounded -> FALL; else exactly one direction key -> WALK; else -> STAND.
REQ-025 JUMP: on tick_ver, pos_y decrements by 1; -> FALL when pos_y <= y_start - JUMP_HEIGHT, ceiling = 1, or pos_y = 0.
REQ-026 FALL: on tick_ver, if not grounded, pos_y increments by 1, saturating at Y_FLOOR; when grounded -> STAND with no pos_y change.
REQ-027 Horizontal, all states: on tick_hor, left only and wall_l = 0 -> pos_x = max(pos_x - HOR_SPEED, X_MIN); right only and wall_r = 0 -> pos_x = min(pos_x + HOR_SPEED, X_MAX); both or neither keys -> no change.
REQ-028 y_start - JUMP_HEIGHT SHALL be computed without underflow; if y_start < JUMP_HEIGHT, the limit is 0.
REQ-029 enable = 0 SHALL hold pos_x, pos_y, state and tick counters; the key_jump edge register keeps sampling.
REQ-030 respawn = 1 SHALL, next cycle, set pos_x = X_START, pos_y = Y_START, state = STAND, regardless of enable; respawn takes priority over all motion.
REQ-031 Simultaneous tick_hor and tick_ver SHALL apply both updates in the same cycle.

Reset
REQ-032 rst SHALL give pos_x = X_START, pos_y = Y_START, state = STAND, y_start = Y_START, tick counters = 0, key_jump edge register = 0, airborne = 0.
REQ-033 rst mid-jump SHALL abandon the jump with no residual motion.

Structure
REQ-034 The state enum and default geometry constants SHALL live in shared package move_pkg; HOR_PIXELS and related constants come from vga_pkg.
REQ-035 A sub-module tick_gen (parameter DIV, outputs tick) SHALL be instantiated twice.

Verification
REQ-036 Reset, then hold ground = 1 with no keys for 3*HOR_DIV cycles -> pos = (100, 533), state = STAND.
REQ-037 Press key_right for 10 horizontal ticks -> pos_x = 130; assert wall_r -> pos_x freezes; both keys -> no change.
REQ-038 Jump request from y = 533, ground = 0 once airborne -> pos_y reaches 433, FALL, returns to 533, STAND; holding key_jump causes no second jump.
REQ-039 Jump with ceiling = 1 after 20 vertical ticks -> FALL at pos_y = 513.
REQ-040 Walk off a platform (ground drops while pos_y = 400) -> FALL and descend until ground = 1.
REQ-041 Respawn pulse with enable = 0 mid-jump -> (100, 533), STAND next cycle; pos_x at X_MIN with left held stays at X_MIN.
